// File: rtl/ins_fetch.sv
// rtl/ins_fetch.sv - byte-serial instruction fetch with a small instruction/pc FIFO
module ins_fetch #(
   parameter logic [31:0] RESET_PC   = 32'h0,
   parameter int          QDEPTH_LOG = 2
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   input  logic        stall_in,
   input  logic        jmp_flg,
   input  logic [31:0] jmp_pc,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_gnt,
   input  logic [7:0]  mem_din,
   output logic        ins_flg,
   output logic [31:0] ins,
   output logic [31:0] pc
);

   localparam int DEPTH = 1 << QDEPTH_LOG;
   localparam logic [QDEPTH_LOG-1:0] PTR_ONE = 1;
   localparam logic [QDEPTH_LOG:0]   CNT_ONE = 1;
   localparam logic [QDEPTH_LOG:0]   CNT_FULL = (QDEPTH_LOG+1)'(DEPTH);

   typedef enum logic {S_REQ, S_WAIT} state_t;

   state_t                state_q;
   logic [1:0]            byte_cnt_q;
   logic [31:0]           fetch_pc_q;
   logic [23:0]           word_q;
   logic [31:0]           ins_mem_q [DEPTH];
   logic [31:0]           pc_mem_q  [DEPTH];
   logic [QDEPTH_LOG-1:0] head_q, tail_q;
   logic [QDEPTH_LOG:0]   count_q, count_d;
   logic                  push, pop;

   // A new word may only start with room in the FIFO; a word already begun always completes.
   assign mem_req  = rdy_in & ~rst_in & (state_q == S_REQ) &
                     ((count_q < CNT_FULL) | (byte_cnt_q != 2'd0));
   assign mem_addr = fetch_pc_q + 32'(byte_cnt_q);
   assign ins_flg  = rdy_in & (count_q != '0) & ~stall_in & ~jmp_flg;
   assign ins      = ins_mem_q[head_q];
   assign pc       = pc_mem_q[head_q];

   assign pop  = ins_flg;
   assign push = rdy_in & ~jmp_flg & (state_q == S_WAIT) & (byte_cnt_q == 2'd3);

   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q    <= S_REQ;
         byte_cnt_q <= 2'd0;
         fetch_pc_q <= RESET_PC;
         word_q     <= '0;
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            ins_mem_q[i] <= '0;
            pc_mem_q[i]  <= '0;
         end
      end else if (rdy_in) begin
         if (jmp_flg) begin
            // Redirect drops any in-flight grant or returning byte.
            state_q    <= S_REQ;
            byte_cnt_q <= 2'd0;
            fetch_pc_q <= jmp_pc;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
         end else begin
            case (state_q)
               S_REQ: begin
                  if (mem_req && mem_gnt) state_q <= S_WAIT;
               end
               S_WAIT: begin
                  state_q <= S_REQ;
                  case (byte_cnt_q)
                     2'd0: word_q[7:0]   <= mem_din;
                     2'd1: word_q[15:8]  <= mem_din;
                     2'd2: word_q[23:16] <= mem_din;
                     default: begin
                        ins_mem_q[tail_q] <= {mem_din, word_q};
                        pc_mem_q[tail_q]  <= fetch_pc_q;
                        tail_q            <= tail_q + PTR_ONE;
                        fetch_pc_q        <= fetch_pc_q + 32'd4;
                     end
                  endcase
                  byte_cnt_q <= byte_cnt_q + 2'd1;
               end
               default: state_q <= S_REQ;
            endcase
            if (pop) head_q <= head_q + PTR_ONE;
            count_q <= count_d;
         end
      end
   end

endmodule

// File: tb/tb_ins_fetch.sv
// tb/tb_ins_fetch.sv - directed and randomized checks of ins_fetch against a pc-stream model
module tb_ins_fetch;

   logic        clk_in = 1'b0;
   logic        rst_in, rdy_in, stall_in, jmp_flg, mem_gnt;
   logic [31:0] jmp_pc;
   logic [7:0]  mem_din;
   logic        mem_req, ins_flg;
   logic [31:0] mem_addr, ins, pc;

   ins_fetch dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .stall_in(stall_in),
      .jmp_flg(jmp_flg), .jmp_pc(jmp_pc), .mem_req(mem_req), .mem_addr(mem_addr),
      .mem_gnt(mem_gnt), .mem_din(mem_din), .ins_flg(ins_flg), .ins(ins), .pc(pc)
   );

   always #5 clk_in = ~clk_in;

   int          checks = 0;
   int          errors = 0;
   int          delivered = 0;
   logic [31:0] exp_pc = 32'h0;

   initial begin
      #1000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [7:0] byte_of(input logic [31:0] a);
      logic [31:0] h;
      case (a)
         32'd0:   return 8'h93;
         32'd1:   return 8'h00;
         32'd2:   return 8'h10;
         32'd3:   return 8'h00;
         default: begin
            h = a * 32'h9E3779B1;
            return h[31:24] ^ a[7:0];
         end
      endcase
   endfunction

   function automatic logic [31:0] word_of(input logic [31:0] p);
      return {byte_of(p + 32'd3), byte_of(p + 32'd2), byte_of(p + 32'd1), byte_of(p)};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
      end
   endtask

   // Sample after inputs settle; the model is just the expected in-order pc stream.
   task automatic settle();
      #1;
      if (!rst_in) begin
         if (!(rdy_in && !stall_in && !jmp_flg)) chk("ins_flg_gated", 32'(ins_flg), 32'd0);
         if (!rdy_in) chk("mem_req_frozen", 32'(mem_req), 32'd0);
         if (ins_flg === 1'b1) begin
            chk("sb_pc", pc, exp_pc);
            chk("sb_ins", ins, word_of(exp_pc));
            exp_pc = exp_pc + 32'd4;
            delivered++;
         end
         if (rdy_in && jmp_flg) exp_pc = jmp_pc;
      end
   endtask

   task automatic tick();
      logic        g;
      logic        froze;
      logic [31:0] a;
      g     = mem_req & mem_gnt;
      a     = mem_addr;
      froze = !rdy_in;
      @(posedge clk_in);
      #1;
      if (g) mem_din = byte_of(a);
      else if (!froze) mem_din = 8'($urandom);
   endtask

   task automatic cycle();
      settle();
      tick();
   endtask

   task automatic do_reset(input logic stall_v);
      rst_in = 1'b1; rdy_in = 1'b1; stall_in = stall_v; jmp_flg = 1'b0; mem_gnt = 1'b1;
      tick();
      tick();
      rst_in = 1'b0;
      exp_pc = 32'h0;
   endtask

   task automatic first_word();
      for (int c = 0; c <= 8; c++) begin
         settle();
         if (c == 0) begin
            chk("restart_req", 32'(mem_req), 32'd1);
            chk("restart_addr", mem_addr, 32'h0);
         end
         chk($sformatf("first_flg_c%0d", c), 32'(ins_flg), 32'(c == 8));
         if (c == 8) begin
            chk("first_ins", ins, 32'h00100093);
            chk("first_pc", pc, 32'h0);
         end
         tick();
      end
   endtask

   task automatic wait_ins(input logic [31:0] want, input string tag);
      logic got;
      got = 1'b0;
      for (int c = 0; c < 40 && !got; c++) begin
         settle();
         if (ins_flg === 1'b1) begin
            chk(tag, pc, want);
            got = 1'b1;
         end
         tick();
      end
      if (!got) chk({tag, "_timeout"}, 32'd0, 32'd1);
   endtask

   initial begin
      int grants;
      rst_in = 1'b1; rdy_in = 1'b1; stall_in = 1'b0; jmp_flg = 1'b0;
      jmp_pc = 32'h0; mem_gnt = 1'b1; mem_din = 8'h00;
      #2;
      chk("rst_mem_req", 32'(mem_req), 32'd0);
      chk("rst_ins_flg", 32'(ins_flg), 32'd0);
      chk("rst_ins", ins, 32'h0);
      chk("rst_pc", pc, 32'h0);

      // Immediate grants: first instruction 8 cycles after reset release.
      do_reset(1'b0);
      first_word();

      // Stalled fill stops at 4 words, then pop and push coincide.
      do_reset(1'b1);
      grants = 0;
      for (int c = 0; c < 60; c++) begin
         settle();
         if (mem_req && mem_gnt) grants++;
         tick();
      end
      chk("fill_grants", 32'(grants), 32'd16);
      settle();
      chk("full_no_req", 32'(mem_req), 32'd0);
      tick();
      stall_in = 1'b0;
      settle();
      chk("pop0_flg", 32'(ins_flg), 32'd1);
      chk("pop0_pc", pc, 32'h0);
      tick();
      stall_in = 1'b1;
      for (int c = 0; c < 7; c++) cycle();
      stall_in = 1'b0;
      settle();
      chk("pushpop_flg", 32'(ins_flg), 32'd1);
      chk("pushpop_pc", pc, 32'h4);
      tick();
      stall_in = 1'b1;
      settle();
      chk("after_pushpop_req", 32'(mem_req), 32'd1);
      tick();
      for (int c = 0; c < 12; c++) cycle();
      settle();
      chk("refull_no_req", 32'(mem_req), 32'd0);
      tick();
      stall_in = 1'b0;
      for (int i = 0; i < 5; i++) begin
         settle();
         chk($sformatf("drain_flg%0d", i), 32'(ins_flg), 32'(i < 4));
         if (i < 4) chk($sformatf("drain_pc%0d", i), pc, 32'h8 + 32'(4 * i));
         tick();
      end

      // Redirect during the byte-2 wait with one word buffered.
      do_reset(1'b1);
      for (int c = 0; c < 13; c++) cycle();
      stall_in = 1'b0; jmp_flg = 1'b1; jmp_pc = 32'h100;
      settle();
      chk("jmp_flg_blocks", 32'(ins_flg), 32'd0);
      tick();
      jmp_flg = 1'b0;
      settle();
      chk("jmp_empty", 32'(ins_flg), 32'd0);
      chk("jmp_req", 32'(mem_req), 32'd1);
      chk("jmp_addr", mem_addr, 32'h100);
      tick();
      wait_ins(32'h100, "jmp_first_pc");

      // Grant withheld in S_REQ of byte 1.
      jmp_flg = 1'b1; jmp_pc = 32'h2000;
      cycle();
      jmp_flg = 1'b0;
      cycle();
      cycle();
      mem_gnt = 1'b0;
      for (int c = 0; c < 5; c++) begin
         settle();
         chk($sformatf("hold_req%0d", c), 32'(mem_req), 32'd1);
         chk($sformatf("hold_addr%0d", c), mem_addr, 32'h2001);
         tick();
      end
      mem_gnt = 1'b1;
      wait_ins(32'h2000, "hold_pc");

      // Address wrap.
      jmp_flg = 1'b1; jmp_pc = 32'hFFFF_FFFC;
      cycle();
      jmp_flg = 1'b0;
      wait_ins(32'hFFFF_FFFC, "wrap_pc0");
      wait_ins(32'h0, "wrap_pc1");

      // Random traffic against the pc-stream model.
      delivered = 0;
      for (int c = 0; c < 1500; c++) begin
         rdy_in   = ($urandom % 10) != 0;
         stall_in = ($urandom % 4) == 0;
         mem_gnt  = ($urandom % 3) != 0;
         jmp_flg  = ($urandom % 50) == 0;
         jmp_pc   = 32'($urandom) & ~32'h3;
         cycle();
      end
      chk("rand_progress", 32'(delivered > 40), 32'd1);

      // Async reset mid-word.
      rdy_in = 1'b1; stall_in = 1'b0; mem_gnt = 1'b1; jmp_flg = 1'b1; jmp_pc = 32'h3000;
      cycle();
      jmp_flg = 1'b0;
      for (int c = 0; c < 4; c++) cycle();
      settle();
      chk("mid_addr", mem_addr, 32'h3002);
      rst_in = 1'b1;
      #1;
      chk("async_req", 32'(mem_req), 32'd0);
      chk("async_addr", mem_addr, 32'h0);
      chk("async_flg", 32'(ins_flg), 32'd0);
      chk("async_ins", ins, 32'h0);
      chk("async_pc", pc, 32'h0);
      tick();
      tick();
      rst_in = 1'b0;
      exp_pc = 32'h0;
      first_word();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
